pe_disable_pipe: RTL and testbench
==================================

Name: pe_disable_pipe

Overview:
- Parametrised successor to the PE zero-skip disable generator.
- Takes a per-lane "operand is zero / skip" flag and produces per-stage disable strobes (psum, mult, iact reg, filter reg, …), each delayed to line up with its PE pipeline stage.
- Generalised over lane count, pipeline depth and number of disable outputs.
- Adds runtime-programmable per-output tap delays, a stall input, a synchronous flush and a saturating skip counter for energy statistics.
- Sits between the PE control/zero-detect logic and the PE datapath clock-enable inputs.

Parameters:
- LANES, 1, number of independent flag lanes (PEs or SIMD lanes) sharing one tap configuration.
- DEPTH, 4, shift-register stages per lane; the maximum delay is DEPTH cycles.
- N_OUT, 4, disable outputs per lane; index 0 = psum, 1 = mult, 2 = iact reg, 3 = filter reg.
- TAPW, $clog2(DEPTH), width of one tap select.
- RST_TAPS, {2'd0,2'd0,2'd1,2'd2}, packed N_OUT×TAPW reset tap values, with out0 in the LSBs.
- CNTW, 16, width of the skip counter.

Ports:
- clk, in, 1, clock, rising edge.
- rstn, in, 1, synchronous active-low reset.
- en, in, 1, pipeline advance; when low, all state holds.
- clear, in, 1, synchronous flush of the pipeline and the counter.
- flag_in, in, LANES, per-lane skip flag, sampled when en=1.
- cfg_we, in, 1, tap write strobe.
- cfg_idx, in, $clog2(N_OUT) (min 1), output index to reprogram.
- cfg_tap, in, TAPW, new tap value.
- dis, out, LANES*N_OUT, disable strobes; bit lane*N_OUT+o.
- busy, out, 1, OR of all stage bits of all lanes.
- skip_cnt, out, CNTW, count of accepted cycles with any flag_in bit set.

Behaviour:
- State:
  - stage[l][0..DEPTH-1], one bit each, per lane.
  - tap[o], TAPW bits each.
  - skip_cnt.
- Output path: dis[l*N_OUT+o] = stage[l][tap[o]]. This is a mux of flops only; there is no combinational path from flag_in, en or clear to dis or busy.
- Latency: a flag accepted at edge k appears on an output with tap t after edge k+t. The delay is t+1 cycles counted from flag_in valid.
- With the default taps this gives:
  - psum: 3-cycle delay.
  - mult: 2-cycle delay.
  - iact and filter: 1-cycle delay.
- Priority per edge: rstn=0 > clear > en.
- Reset (rstn=0):
  - All stage bits and skip_cnt go to 0, so dis=0, busy=0, skip_cnt=0.
  - tap[o] loads RST_TAPS[o].
  - Every register is reset; no uninitialised flops.
- clear=1 (with rstn=1):
  - All stage bits and skip_cnt go to 0; taps are unchanged.
  - flag_in on that cycle is discarded.
  - A cfg write on the same cycle still takes effect.
- en=1, clear=0:
  - stage[l][0] <= flag_in[l].
  - stage[l][i] <= stage[l][i-1] for i=1..DEPTH-1.
  - skip_cnt increments if |flag_in, and saturates at 2^CNTW-1 (it does not wrap).
- en=0, clear=0: stages and skip_cnt hold, so dis holds its value (stall-safe).
- Tap configuration:
  - cfg_we=1 writes tap[cfg_idx] <= cfg_tap, independent of en.
  - A write with cfg_idx >= N_OUT is ignored.
  - A write with cfg_tap >= DEPTH is clamped to DEPTH-1.
  - The new tap drives dis from the following cycle.
  - The pipeline is not flushed on reconfiguration. Software must reprogram only while busy=0; the bench checks output correctness only under that rule.
- Lanes are fully independent apart from the shared taps and the shared skip_cnt.
- Back-to-back flags: the pipeline accepts one flag per cycle with no bubbles. A run of N consecutive flags yields an N-cycle-wide disable pulse on every output.

Decomposition:
- Package pe_dis_pkg holds:
  - output index constants (DIS_PSUM=0, DIS_MULT=1, DIS_IACT=2, DIS_FILT=3);
  - the default RST_TAPS constant;
  - a tap-clamp function.
- One natural sub-module: pe_dis_lane, a DEPTH-bit shift register with en/clear and an N_OUT-way tap mux.
- The top level instantiates LANES copies and owns the tap registers and skip_cnt.

Test Plan:
1. Default delays:
   - Stimulus: reset, en=1, single-cycle flag_in=1 on lane 0 at cycle 10.
   - Required: dis[0] high only in cycle 13; dis[1] only in cycle 12; dis[2] and dis[3] only in cycle 11; busy high cycles 11-14; skip_cnt=1.
2. Stall:
   - Stimulus: same pulse, en=0 for cycles 11-12.
   - Required: stage contents frozen, so dis[0] asserts in cycle 15 instead of 13; no pulse is lost or duplicated.
3. Flush:
   - Stimulus: flag_in=1 for 3 cycles, then clear=1 one cycle later.
   - Required: dis and busy are 0 the next cycle; skip_cnt=0; taps unchanged (verify with a subsequent pulse at the default delays).
4. Reconfiguration:
   - Stimulus: with busy=0, write cfg_idx=1, cfg_tap=3, then a pulse.
   - Required: mult delay becomes 4 cycles.
   - Stimulus: write cfg_idx=5 (N_OUT=4).
   - Required: no tap changes.
   - Stimulus: write cfg_tap beyond DEPTH-1 (requires DEPTH not a power of 2, e.g. DEPTH=3 with cfg_tap=3).
   - Required: clamped to 2.
5. Multi-lane and streaming:
   - Stimulus: LANES=4, DEPTH=8, flag_in=4'b1010 held for 5 cycles.
   - Required: lanes 1 and 3 show 5-cycle-wide pulses at each tap delay; lanes 0 and 2 stay 0; skip_cnt=5.
6. Saturation and reset priority:
   - Stimulus: CNTW=4, flag held for 20 cycles.
   - Required: skip_cnt sticks at 15.
   - Stimulus: assert rstn=0 mid-stream together with clear and cfg_we.
   - Required: everything returns to reset values, with taps equal to RST_TAPS.

Source files
------------

// File: rtl/pe_dis_pkg.sv
// Shared constants and helpers for the PE zero-skip disable pipeline.
package pe_dis_pkg;

   localparam int DIS_PSUM = 0;
   localparam int DIS_MULT = 1;
   localparam int DIS_IACT = 2;
   localparam int DIS_FILT = 3;

   localparam int         DIS_N_OUT_DEF = 4;
   localparam logic [7:0] RST_TAPS_DEF  = {2'd0, 2'd0, 2'd1, 2'd2};

   // Out-of-range tap requests saturate to the deepest stage.
   function automatic int unsigned clamp_tap(input int unsigned tap, input int unsigned depth);
      return (tap >= depth) ? depth - 1 : tap;
   endfunction

endpackage

// File: rtl/pe_dis_lane.sv
// One lane: DEPTH-bit flag shift register with stall/flush and an N_OUT-way tap mux.
module pe_dis_lane
   import pe_dis_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int N_OUT = 4,
   parameter int TAPW  = 2
) (
   input  logic                    clk,
   input  logic                    rstn,
   input  logic                    en,
   input  logic                    clear,
   input  logic                    flag_in,
   input  logic [N_OUT*TAPW-1:0]   taps,
   output logic [N_OUT-1:0]        dis,
   output logic                    busy
);

   logic [DEPTH-1:0] stage_q;
   logic [DEPTH-1:0] stage_d;

   always_comb begin
      stage_d = stage_q;
      if (clear) begin
         stage_d = '0;
      end else if (en) begin
         stage_d[0] = flag_in;
         for (int i = 1; i < DEPTH; i++) begin
            stage_d[i] = stage_q[i-1];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         stage_q <= '0;
      end else begin
         stage_q <= stage_d;
      end
   end

   // Pure flop mux: a tap value with no matching stage reads as 0.
   always_comb begin
      dis = '0;
      for (int o = 0; o < N_OUT; o++) begin
         for (int i = 0; i < DEPTH; i++) begin
            if (taps[o*TAPW +: TAPW] == TAPW'(i)) begin
               dis[o] = stage_q[i];
            end
         end
      end
   end

   assign busy = |stage_q;

endmodule

// File: rtl/pe_disable_pipe.sv
// Per-lane zero-skip disable generator: delays skip flags onto per-stage disable strobes.
module pe_disable_pipe
   import pe_dis_pkg::*;
#(
   parameter int                     LANES    = 1,
   parameter int                     DEPTH    = 4,
   parameter int                     N_OUT    = DIS_N_OUT_DEF,
   parameter int                     TAPW     = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   parameter logic [N_OUT*TAPW-1:0]  RST_TAPS = (N_OUT*TAPW)'(RST_TAPS_DEF),
   parameter int                     CNTW     = 16,
   localparam int                    IDXW     = (N_OUT > 1) ? $clog2(N_OUT) : 1
) (
   input  logic                     clk,
   input  logic                     rstn,
   input  logic                     en,
   input  logic                     clear,
   input  logic [LANES-1:0]         flag_in,
   input  logic                     cfg_we,
   input  logic [IDXW-1:0]          cfg_idx,
   input  logic [TAPW-1:0]          cfg_tap,
   output logic [LANES*N_OUT-1:0]   dis,
   output logic                     busy,
   output logic [CNTW-1:0]          skip_cnt
);

   logic [N_OUT*TAPW-1:0] tap_q;
   logic [N_OUT*TAPW-1:0] tap_d;
   logic [CNTW-1:0]       skip_cnt_q;
   logic [CNTW-1:0]       skip_cnt_d;
   logic [LANES-1:0]      lane_busy;

   // Tap writes are accepted under clear and stall alike.
   always_comb begin
      tap_d = tap_q;
      if (cfg_we && (32'(cfg_idx) < N_OUT)) begin
         tap_d[cfg_idx*TAPW +: TAPW] = TAPW'(clamp_tap(32'(cfg_tap), DEPTH));
      end
   end

   always_comb begin
      skip_cnt_d = skip_cnt_q;
      if (clear) begin
         skip_cnt_d = '0;
      end else if (en && (|flag_in) && (skip_cnt_q != '1)) begin
         skip_cnt_d = skip_cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         tap_q      <= RST_TAPS;
         skip_cnt_q <= '0;
      end else begin
         tap_q      <= tap_d;
         skip_cnt_q <= skip_cnt_d;
      end
   end

   for (genvar l = 0; l < LANES; l++) begin : g_lane
      pe_dis_lane #(
         .DEPTH (DEPTH),
         .N_OUT (N_OUT),
         .TAPW  (TAPW)
      ) u_lane (
         .clk     (clk),
         .rstn    (rstn),
         .en      (en),
         .clear   (clear),
         .flag_in (flag_in[l]),
         .taps    (tap_q),
         .dis     (dis[l*N_OUT +: N_OUT]),
         .busy    (lane_busy[l])
      );
   end

   assign busy     = |lane_busy;
   assign skip_cnt = skip_cnt_q;

endmodule

// File: tb/tb_pe_disable_pipe.sv
// Bench for pe_disable_pipe: directed table on the default build, plus corner and random runs on two other builds.
module tb_pe_disable_pipe;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // ---------------- DUT A: defaults (1 lane, DEPTH 4, 4 outputs) ----------------
   logic        a_rstn, a_en, a_clear, a_we;
   logic [0:0]  a_flag;
   logic [1:0]  a_idx, a_tap;
   logic [3:0]  a_dis;
   logic        a_busy;
   logic [15:0] a_cnt;

   pe_disable_pipe u_a (
      .clk(clk), .rstn(a_rstn), .en(a_en), .clear(a_clear), .flag_in(a_flag),
      .cfg_we(a_we), .cfg_idx(a_idx), .cfg_tap(a_tap),
      .dis(a_dis), .busy(a_busy), .skip_cnt(a_cnt)
   );

   // ---------------- DUT B: 4 lanes, DEPTH 8 ----------------
   logic        b_rstn, b_en, b_clear, b_we;
   logic [3:0]  b_flag;
   logic [1:0]  b_idx;
   logic [2:0]  b_tap;
   logic [15:0] b_dis;
   logic        b_busy;
   logic [15:0] b_cnt;

   pe_disable_pipe #(
      .LANES(4), .DEPTH(8), .N_OUT(4), .TAPW(3),
      .RST_TAPS({3'd0, 3'd1, 3'd4, 3'd7}), .CNTW(16)
   ) u_b (
      .clk(clk), .rstn(b_rstn), .en(b_en), .clear(b_clear), .flag_in(b_flag),
      .cfg_we(b_we), .cfg_idx(b_idx), .cfg_tap(b_tap),
      .dis(b_dis), .busy(b_busy), .skip_cnt(b_cnt)
   );

   // ---------------- DUT C: DEPTH 3, 3 outputs, 4-bit counter ----------------
   logic        c_rstn, c_en, c_clear, c_we;
   logic [0:0]  c_flag;
   logic [1:0]  c_idx, c_tap;
   logic [2:0]  c_dis;
   logic        c_busy;
   logic [3:0]  c_cnt;

   pe_disable_pipe #(
      .LANES(1), .DEPTH(3), .N_OUT(3), .TAPW(2),
      .RST_TAPS({2'd0, 2'd1, 2'd2}), .CNTW(4)
   ) u_c (
      .clk(clk), .rstn(c_rstn), .en(c_en), .clear(c_clear), .flag_in(c_flag),
      .cfg_we(c_we), .cfg_idx(c_idx), .cfg_tap(c_tap),
      .dis(c_dis), .busy(c_busy), .skip_cnt(c_cnt)
   );

   // ---------------- directed table for DUT A ----------------
   typedef struct {
      logic        rstn, en, clear, flag, we;
      logic [1:0]  idx, tap;
      logic [3:0]  dis;
      logic        busy;
      logic [15:0] cnt;
   } vec_t;

   vec_t va[$];

   task automatic add(input logic rstn, en, clear, flag, we, input logic [1:0] idx, tap,
                      input logic [3:0] dis, input logic busy, input logic [15:0] cnt);
      vec_t v;
      v.rstn = rstn; v.en = en; v.clear = clear; v.flag = flag; v.we = we;
      v.idx = idx; v.tap = tap; v.dis = dis; v.busy = busy; v.cnt = cnt;
      va.push_back(v);
   endtask

   task automatic addf(input logic flag, input logic [3:0] dis, input logic busy, input logic [15:0] cnt);
      add(1, 1, 0, flag, 0, 0, 0, dis, busy, cnt);
   endtask

   // ---------------- reference model for DUT B ----------------
   logic [3:0] hist [8];
   int         tap_m [4];
   int         cnt_m;

   function automatic logic [15:0] model_dis();
      logic [15:0] d;
      d = '0;
      for (int l = 0; l < 4; l++)
         for (int o = 0; o < 4; o++)
            d[l*4+o] = hist[tap_m[o]][l];
      return d;
   endfunction

   function automatic logic model_busy();
      logic b;
      b = 1'b0;
      for (int i = 0; i < 8; i++) b = b | (|hist[i]);
      return b;
   endfunction

   task automatic b_step(input logic rstn, en, clear, input logic [3:0] flag,
                         input logic we, input logic [1:0] idx, input logic [2:0] tap);
      b_rstn = rstn; b_en = en; b_clear = clear; b_flag = flag;
      b_we = we; b_idx = idx; b_tap = tap;
      if (!rstn) begin
         for (int i = 0; i < 8; i++) hist[i] = '0;
         tap_m[0] = 7; tap_m[1] = 4; tap_m[2] = 1; tap_m[3] = 0;
         cnt_m = 0;
      end else begin
         if (clear) begin
            for (int i = 0; i < 8; i++) hist[i] = '0;
            cnt_m = 0;
         end else if (en) begin
            for (int i = 7; i > 0; i--) hist[i] = hist[i-1];
            hist[0] = flag;
            if (flag != 0 && cnt_m < 65535) cnt_m++;
         end
         if (we) tap_m[idx] = int'(tap);
      end
      @(negedge clk);
      check("b_dis",  64'(b_dis),  64'(model_dis()));
      check("b_busy", 64'(b_busy), 64'(model_busy()));
      check("b_cnt",  64'(b_cnt),  64'(cnt_m));
   endtask

   task automatic c_step(input logic rstn, en, clear, flag, we, input logic [1:0] idx, tap);
      c_rstn = rstn; c_en = en; c_clear = clear; c_flag = flag;
      c_we = we; c_idx = idx; c_tap = tap;
      @(negedge clk);
   endtask

   task automatic c_expect(input string nm, input logic [2:0] dis, input logic busy);
      check({nm, "_dis"},  64'(c_dis),  64'(dis));
      check({nm, "_busy"}, 64'(c_busy), 64'(busy));
   endtask

   initial begin
      a_rstn = 0; a_en = 0; a_clear = 0; a_flag = 0; a_we = 0; a_idx = 0; a_tap = 0;
      b_rstn = 0; b_en = 0; b_clear = 0; b_flag = 0; b_we = 0; b_idx = 0; b_tap = 0;
      c_rstn = 0; c_en = 0; c_clear = 0; c_flag = 0; c_we = 0; c_idx = 0; c_tap = 0;

      // reset and idle
      add(0, 0, 0, 0, 0, 0, 0, 4'b0000, 0, 0);
      add(0, 1, 0, 1, 0, 0, 0, 4'b0000, 0, 0);
      for (int i = 0; i < 3; i++) addf(0, 4'b0000, 0, 0);
      // single pulse at default delays
      addf(1, 4'b1100, 1, 1);
      addf(0, 4'b0010, 1, 1);
      addf(0, 4'b0001, 1, 1);
      addf(0, 4'b0000, 1, 1);
      addf(0, 4'b0000, 0, 1);
      // stall for two cycles; flag during stall is ignored
      addf(1, 4'b1100, 1, 2);
      add(1, 0, 0, 1, 0, 0, 0, 4'b1100, 1, 2);
      add(1, 0, 0, 1, 0, 0, 0, 4'b1100, 1, 2);
      addf(0, 4'b0010, 1, 2);
      addf(0, 4'b0001, 1, 2);
      addf(0, 4'b0000, 1, 2);
      addf(0, 4'b0000, 0, 2);
      // 3-cycle run then flush; flag on the flush cycle is discarded
      addf(1, 4'b1100, 1, 3);
      addf(1, 4'b1110, 1, 4);
      addf(1, 4'b1111, 1, 5);
      add(1, 1, 1, 1, 0, 0, 0, 4'b0000, 0, 0);
      addf(1, 4'b1100, 1, 1);
      addf(0, 4'b0010, 1, 1);
      addf(0, 4'b0001, 1, 1);
      addf(0, 4'b0000, 1, 1);
      addf(0, 4'b0000, 0, 1);
      // mult tap -> 3
      add(1, 1, 0, 0, 1, 2'd1, 2'd3, 4'b0000, 0, 1);
      addf(1, 4'b1100, 1, 2);
      addf(0, 4'b0000, 1, 2);
      addf(0, 4'b0001, 1, 2);
      addf(0, 4'b0010, 1, 2);
      addf(0, 4'b0000, 0, 2);
      // psum tap -> 0, written while stalled
      add(1, 0, 0, 0, 1, 2'd0, 2'd0, 4'b0000, 0, 2);
      addf(1, 4'b1101, 1, 3);
      addf(0, 4'b0000, 1, 3);
      addf(0, 4'b0000, 1, 3);
      addf(0, 4'b0010, 1, 3);
      addf(0, 4'b0000, 0, 3);
      // reset mid-stream beats clear and cfg write
      addf(1, 4'b1101, 1, 4);
      addf(1, 4'b1101, 1, 5);
      add(0, 1, 1, 1, 1, 2'd2, 2'd3, 4'b0000, 0, 0);
      addf(1, 4'b1100, 1, 1);
      addf(0, 4'b0010, 1, 1);
      addf(0, 4'b0001, 1, 1);
      addf(0, 4'b0000, 1, 1);
      addf(0, 4'b0000, 0, 1);
      // cfg write on a clear cycle still lands: filt tap -> 2
      add(1, 1, 1, 0, 1, 2'd3, 2'd2, 4'b0000, 0, 0);
      addf(1, 4'b0100, 1, 1);
      addf(0, 4'b0010, 1, 1);
      addf(0, 4'b1001, 1, 1);
      addf(0, 4'b0000, 1, 1);
      addf(0, 4'b0000, 0, 1);

      @(negedge clk);
      foreach (va[i]) begin
         a_rstn = va[i].rstn; a_en = va[i].en; a_clear = va[i].clear; a_flag = va[i].flag;
         a_we = va[i].we; a_idx = va[i].idx; a_tap = va[i].tap;
         @(negedge clk);
         check($sformatf("a%0d_dis", i),  64'(a_dis),  64'(va[i].dis));
         check($sformatf("a%0d_busy", i), 64'(a_busy), 64'(va[i].busy));
         check($sformatf("a%0d_cnt", i),  64'(a_cnt),  64'(va[i].cnt));
      end

      // ---------------- DUT C: ignored index, clamp, saturation, reset priority ----------------
      c_step(0, 0, 0, 0, 0, 0, 0);
      c_step(0, 0, 0, 0, 0, 0, 0);
      c_expect("c_rst", 3'b000, 0);
      check("c_rst_cnt", 64'(c_cnt), 64'd0);
      c_step(1, 1, 0, 0, 1, 2'd3, 2'd0);
      c_step(1, 1, 0, 1, 0, 0, 0);  c_expect("c_ign0", 3'b100, 1);
      c_step(1, 1, 0, 0, 0, 0, 0);  c_expect("c_ign1", 3'b010, 1);
      c_step(1, 1, 0, 0, 0, 0, 0);  c_expect("c_ign2", 3'b001, 1);
      c_step(1, 1, 0, 0, 0, 0, 0);  c_expect("c_ign3", 3'b000, 0);
      c_step(1, 1, 0, 0, 1, 2'd2, 2'd3);
      c_step(1, 1, 0, 1, 0, 0, 0);  c_expect("c_clp0", 3'b000, 1);
      c_step(1, 1, 0, 0, 0, 0, 0);  c_expect("c_clp1", 3'b010, 1);
      c_step(1, 1, 0, 0, 0, 0, 0);  c_expect("c_clp2", 3'b101, 1);
      c_step(1, 1, 0, 0, 0, 0, 0);  c_expect("c_clp3", 3'b000, 0);
      check("c_cnt2", 64'(c_cnt), 64'd2);
      for (int i = 0; i < 20; i++) begin
         c_step(1, 1, 0, 1, 0, 0, 0);
         if (i == 11) check("c_cnt14", 64'(c_cnt), 64'd14);
      end
      check("c_sat", 64'(c_cnt), 64'd15);
      c_step(0, 1, 1, 1, 1, 2'd2, 2'd0);
      c_expect("c_rstp", 3'b000, 0);
      check("c_rstp_cnt", 64'(c_cnt), 64'd0);
      c_step(1, 1, 0, 1, 0, 0, 0);  c_expect("c_rtap0", 3'b100, 1);
      c_step(1, 1, 0, 0, 0, 0, 0);  c_expect("c_rtap1", 3'b010, 1);
      c_step(1, 1, 0, 0, 0, 0, 0);  c_expect("c_rtap2", 3'b001, 1);

      // ---------------- DUT B: streaming 1010 then random ----------------
      begin
         int w_hi, w_zero;
         w_hi = 0; w_zero = 0;
         b_step(0, 0, 0, 4'h0, 0, 0, 0);
         b_step(0, 0, 0, 4'h0, 0, 0, 0);
         for (int i = 0; i < 16; i++) begin
            b_step(1, 1, 0, (i < 5) ? 4'b1010 : 4'b0000, 0, 0, 0);
            if (b_dis[4]) w_hi++;
            if ((b_dis[3:0] | b_dis[11:8]) != 0) w_zero++;
            if (i == 4) check("b_cnt5", 64'(b_cnt), 64'd5);
         end
         check("b_width_l1o0", 64'(w_hi), 64'd5);
         check("b_quiet_l0l2", 64'(w_zero), 64'd0);
      end
      for (int i = 0; i < 400; i++) begin
         logic       en_r, clr_r, we_r;
         logic [3:0] fl_r;
         en_r  = ($urandom_range(0, 3) != 0);
         clr_r = ($urandom_range(0, 31) == 0);
         fl_r  = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
         we_r  = !model_busy() && ($urandom_range(0, 3) == 0);
         b_step(1, en_r, clr_r, fl_r, we_r, 2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)));
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
